wb_port_arbiter: RTL

- Shares the single register-file write port between the Mult, AluMisc and Mem writeback sources.
- Each source has its own FIFO buffer. The arbiter grants at most one write per cycle and drives the registered wb_reg_* outputs to the register file.
- A source is stalled when its FIFO is full. An aging counter prevents starvation of low-priority sources.

---
 rtl/wb_port_if.sv | 41 ++++
 rtl/wb_port_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/wb_port_if.sv
// Bus bundle between the three writeback units and the register-file write arbiter.
// The arbiter side uses the slave modport; the driving side uses master.
interface wb_port_if;
  logic        mul_wb_oper;
  logic        mul_wb_writereg;
  logic [4:0]  mul_wb_regdest;
  logic [31:0] mul_wb_wbvalue;
  logic        mul_wb_stall;

  logic        am_wb_oper;
  logic        am_wb_writereg;
  logic [4:0]  am_wb_regdest;
  logic [31:0] am_wb_wbvalue;
  logic        am_wb_stall;

  logic        mem_wb_oper;
  logic        mem_wb_writereg;
  logic [4:0]  mem_wb_regdest;
  logic [31:0] mem_wb_wbvalue;
  logic        mem_wb_stall;

  logic        wb_reg_en;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_reg_data;

  modport slave (
    input  mul_wb_oper, mul_wb_writereg, mul_wb_regdest, mul_wb_wbvalue,
    input  am_wb_oper, am_wb_writereg, am_wb_regdest, am_wb_wbvalue,
    input  mem_wb_oper, mem_wb_writereg, mem_wb_regdest, mem_wb_wbvalue,
    output mul_wb_stall, am_wb_stall, mem_wb_stall,
    output wb_reg_en, wb_reg_addr, wb_reg_data
  );

  modport master (
    output mul_wb_oper, mul_wb_writereg, mul_wb_regdest, mul_wb_wbvalue,
    output am_wb_oper, am_wb_writereg, am_wb_regdest, am_wb_wbvalue,
    output mem_wb_oper, mem_wb_writereg, mem_wb_regdest, mem_wb_wbvalue,
    input  mul_wb_stall, am_wb_stall, mem_wb_stall,
    input  wb_reg_en, wb_reg_addr, wb_reg_data
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between Mult, AluMisc and Mem writeback sources,
// each buffered in its own FIFO, with fixed priority plus an anti-starvation aging promotion.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      rst,
  wb_port_if.slave  bus
);
  localparam int NSRC = 3;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int AW   = $clog2(STARVE_LIMIT + 1);

  typedef logic [36:0] entry_t;

  // Source index doubles as fixed priority: 0 = Mult, 1 = AluMisc, 2 = Mem (highest).
  logic [NSRC-1:0] src_oper;
  logic [NSRC-1:0] src_writereg;
  logic [4:0]      src_regdest [NSRC];
  logic [31:0]     src_wbvalue [NSRC];

  logic [NSRC-1:0] stall;
  logic [NSRC-1:0] nonempty;
  logic [NSRC-1:0] starving;
  logic [NSRC-1:0] enq;
  logic [NSRC-1:0] grant;
  entry_t          head [NSRC];

  logic            sel_valid;
  logic [1:0]      sel_idx;

  logic            wb_reg_en_reg;
  logic [4:0]      wb_reg_addr_reg;
  logic [31:0]     wb_reg_data_reg;

  assign src_oper     = {bus.mem_wb_oper, bus.am_wb_oper, bus.mul_wb_oper};
  assign src_writereg = {bus.mem_wb_writereg, bus.am_wb_writereg, bus.mul_wb_writereg};
  assign src_regdest[0] = bus.mul_wb_regdest;
  assign src_regdest[1] = bus.am_wb_regdest;
  assign src_regdest[2] = bus.mem_wb_regdest;
  assign src_wbvalue[0] = bus.mul_wb_wbvalue;
  assign src_wbvalue[1] = bus.am_wb_wbvalue;
  assign src_wbvalue[2] = bus.mem_wb_wbvalue;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      entry_t          buf_mem [DEPTH];
      logic [PW-1:0]   wr_ptr_reg;
      logic [PW-1:0]   rd_ptr_reg;
      logic [CW-1:0]   count_reg;
      logic [AW-1:0]   age_reg;

      assign stall[gi]    = (count_reg == CW'(DEPTH));
      assign nonempty[gi] = (count_reg != '0);
      assign starving[gi] = nonempty[gi] && (age_reg >= AW'(STARVE_LIMIT));
      // Writes with no architectural destination are dropped before they take a slot.
      assign enq[gi]      = src_oper[gi] && src_writereg[gi] &&
                            (src_regdest[gi] != 5'd0) && !stall[gi];
      assign head[gi]     = buf_mem[rd_ptr_reg];

      always_ff @(posedge clk) begin
        if (enq[gi]) begin
          buf_mem[wr_ptr_reg] <= {src_regdest[gi], src_wbvalue[gi]};
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (enq[gi]) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
          end
          if (grant[gi]) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
          end
          if (enq[gi] && !grant[gi]) begin
            count_reg <= count_reg + 1'b1;
          end else if (!enq[gi] && grant[gi]) begin
            count_reg <= count_reg - 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst || grant[gi] || !nonempty[gi]) begin
          age_reg <= '0;
        end else if (age_reg < AW'(STARVE_LIMIT)) begin
          age_reg <= age_reg + 1'b1;
        end
      end
    end
  endgenerate

  // Later loop iterations overwrite earlier ones, so the highest index wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = 2'd0;
    grant     = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (nonempty[i]) begin
        sel_valid = 1'b1;
        sel_idx   = 2'(i);
      end
    end
    if (|starving) begin
      for (int i = 0; i < NSRC; i++) begin
        if (starving[i]) begin
          sel_idx = 2'(i);
        end
      end
    end
    if (sel_valid) begin
      grant[sel_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_reg_en_reg   <= 1'b0;
      wb_reg_addr_reg <= '0;
      wb_reg_data_reg <= '0;
    end else if (sel_valid) begin
      wb_reg_en_reg   <= 1'b1;
      wb_reg_addr_reg <= head[sel_idx][36:32];
      wb_reg_data_reg <= head[sel_idx][31:0];
    end else begin
      wb_reg_en_reg   <= 1'b0;
    end
  end

  assign bus.mul_wb_stall = stall[0];
  assign bus.am_wb_stall  = stall[1];
  assign bus.mem_wb_stall = stall[2];
  assign bus.wb_reg_en    = wb_reg_en_reg;
  assign bus.wb_reg_addr  = wb_reg_addr_reg;
  assign bus.wb_reg_data  = wb_reg_data_reg;
endmodule
